// File: rtl/cr_iu_oper_dbg_acc.sv
// Debug GPR access sequencer: stalls issue, waits for EX/WB to drain, then
// reads GPR port 0 or injects a GPR write on behalf of HAD and acknowledges.
module cr_iu_oper_dbg_acc #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        had_oper_req,
  input  logic        had_oper_wr,
  input  logic [4:0]  had_oper_idx,
  input  logic [31:0] had_oper_wdata,
  output logic        oper_had_ack,
  output logic        oper_had_err,
  output logic [31:0] oper_had_rdata,
  input  logic        ctrl_oper_pipe_idle,
  input  logic        wb_oper_write_en,
  output logic        oper_ctrl_pipe_stall,
  output logic        oper_gpr_rd_sel,
  output logic [4:0]  oper_gpr_rd_idx,
  input  logic [31:0] oper_rs1_gpr_data,
  output logic        oper_gpr_wr_en,
  output logic [4:0]  oper_gpr_wr_idx,
  output logic [31:0] oper_gpr_wr_data
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STALL  = 3'd1,
    ACCESS = 3'd2,
    ACK    = 3'd3,
    DROP   = 3'd4
  } state_e;

  state_e              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                wr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                timeout_c;
  logic                stall_nxt, rd_sel_nxt, wr_en_nxt, ack_nxt;

  // Next state, wait counter and Moore output decode of the next state
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    timeout_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (had_oper_req) state_nxt = STALL;
      end
      STALL: begin
        if (!had_oper_req) begin
          state_nxt = IDLE;
        end else if (ctrl_oper_pipe_idle && !wb_oper_write_en) begin
          state_nxt = ACCESS;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_nxt = ACK;
          timeout_c = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = DROP;
      DROP:    if (!had_oper_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    stall_nxt  = (state_nxt != IDLE);
    rd_sel_nxt = (state_nxt == ACCESS) && !wr_q;
    wr_en_nxt  = (state_nxt == ACCESS) && wr_q && (idx_q != '0);
    ack_nxt    = (state_nxt == ACK);
  end

  // State, request latch and registered outputs
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q              <= IDLE;
      cnt_q                <= '0;
      wr_q                 <= 1'b0;
      idx_q                <= '0;
      wdata_q              <= '0;
      oper_had_ack         <= 1'b0;
      oper_had_err         <= 1'b0;
      oper_had_rdata       <= '0;
      oper_ctrl_pipe_stall <= 1'b0;
      oper_gpr_rd_sel      <= 1'b0;
      oper_gpr_wr_en       <= 1'b0;
    end else begin
      state_q              <= state_nxt;
      cnt_q                <= cnt_nxt;
      oper_had_ack         <= ack_nxt;
      oper_ctrl_pipe_stall <= stall_nxt;
      oper_gpr_rd_sel      <= rd_sel_nxt;
      oper_gpr_wr_en       <= wr_en_nxt;
      if (state_q == IDLE && had_oper_req) begin
        wr_q    <= had_oper_wr;
        idx_q   <= had_oper_idx;
        wdata_q <= had_oper_wdata;
      end
      // r0 is hardwired zero, so its read result is forced rather than sampled
      if (state_q == ACCESS) begin
        oper_had_err <= 1'b0;
        if (!wr_q) oper_had_rdata <= (idx_q == '0) ? '0 : oper_rs1_gpr_data;
      end else if (timeout_c) begin
        oper_had_err <= 1'b1;
      end
    end
  end

  assign oper_gpr_rd_idx  = idx_q;
  assign oper_gpr_wr_idx  = idx_q;
  assign oper_gpr_wr_data = wdata_q;

endmodule

// File: tb/tb_cr_iu_oper_dbg_acc.sv
// Scoreboard bench for cr_iu_oper_dbg_acc: directed requests push expected
// acks/writes; a negedge monitor pops and compares against DUT outputs.
module tb_cr_iu_oper_dbg_acc;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req, wr;
  logic [4:0]  idx;
  logic [31:0] wdata;
  logic        ack, err;
  logic [31:0] rdata;
  logic        pipe_idle, wb_wen;
  logic        stall, rd_sel;
  logic [4:0]  rd_idx;
  logic [31:0] rs1_data;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  cr_iu_oper_dbg_acc #(.TIMEOUT(16)) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_b),
    .had_oper_req         (req),
    .had_oper_wr          (wr),
    .had_oper_idx         (idx),
    .had_oper_wdata       (wdata),
    .oper_had_ack         (ack),
    .oper_had_err         (err),
    .oper_had_rdata       (rdata),
    .ctrl_oper_pipe_idle  (pipe_idle),
    .wb_oper_write_en     (wb_wen),
    .oper_ctrl_pipe_stall (stall),
    .oper_gpr_rd_sel      (rd_sel),
    .oper_gpr_rd_idx      (rd_idx),
    .oper_rs1_gpr_data    (rs1_data),
    .oper_gpr_wr_en       (wr_en),
    .oper_gpr_wr_idx      (wr_idx),
    .oper_gpr_wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  // GPR file model; port 0 carries junk when not selected by the debug path
  logic [31:0] gpr [32];
  assign rs1_data = rd_sel ? gpr[rd_idx] : 32'hBAD0_BAD0;
  always @(posedge clk) if (wr_en) gpr[wr_idx] <= wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } ack_t;
  typedef struct { logic [4:0] idx; logic [31:0] data; int cyc; } wr_t;
  ack_t ack_q [$];
  wr_t  wr_q  [$];

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  logic [4:0] exp_rd_idx = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every ack and write strobe against the scoreboard
  always @(negedge clk) begin : mon
    ack_t ea;
    wr_t  ew;
    if (rst_b === 1'b1) begin
      if (ack) begin
        if (ack_q.size() == 0) check("ack_unexpected", 64'(ack), 64'd0);
        else begin
          ea = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(ea.cyc));
          check("ack_err",   64'(err), 64'(ea.err));
          check("ack_rdata", 64'(rdata), 64'(ea.rdata));
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_en_unexpected", 64'(wr_en), 64'd0);
        else begin
          ew = wr_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(ew.cyc));
          check("wr_idx",   64'(wr_idx), 64'(ew.idx));
          check("wr_data",  64'(wr_data), 64'(ew.data));
        end
      end
      if (rd_sel) begin
        rd_cnt++;
        check("rd_idx", 64'(rd_idx), 64'(exp_rd_idx));
      end
    end
  end

  // Issue one request; busy = cycle in which the pipeline becomes free
  task automatic issue(input bit w, input logic [4:0] i, input logic [31:0] d,
                       input int busy, input bit busy_wb, input bit exp_err,
                       input logic [31:0] exp_rdata, input int lat, input int exp_rd_pulses);
    int  c, rd0;
    bit  stall_ok, got;
    @(negedge clk);
    c = cyc;
    rd0 = rd_cnt;
    ack_q.push_back('{err: exp_err, rdata: exp_rdata, cyc: c + lat});
    if (w && i != 5'd0 && !exp_err) wr_q.push_back('{idx: i, data: d, cyc: c + lat - 1});
    exp_rd_idx = i;
    req = 1'b1; wr = w; idx = i; wdata = d;
    if (busy > 0) begin
      if (busy_wb) wb_wen = 1'b1;
      else         pipe_idle = 1'b0;
    end
    stall_ok = 1'b1;
    got = 1'b0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk);
      if (k == busy) begin pipe_idle = 1'b1; wb_wen = 1'b0; end
      if (!stall) stall_ok = 1'b0;
      if (ack) got = 1'b1;
    end
    check("ack_seen", 64'(got), 64'd1);
    pipe_idle = 1'b1; wb_wen = 1'b0;
    @(negedge clk);
    if (!stall) stall_ok = 1'b0;
    req = 1'b0;
    check("stall_hold", 64'(stall_ok), 64'd1);
    @(negedge clk);
    check("stall_release", 64'(stall), 64'd0);
    check("rd_sel_pulses", 64'(rd_cnt - rd0), 64'(exp_rd_pulses));
  endtask

  initial begin
    for (int k = 0; k < 32; k++) gpr[k] = '0;
    gpr[5] = 32'hDEAD_BEEF;
    gpr[0] = 32'h0BAD_0000;
    rst_b = 1'b0; req = 1'b0; wr = 1'b0; idx = '0; wdata = '0;
    pipe_idle = 1'b1; wb_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 64'({ack, err, stall, rd_sel, wr_en}), 64'd0);
    check("rst_rdata",   64'(rdata), 64'd0);
    check("rst_idx_data", 64'({rd_idx, wr_idx, wr_data}), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    issue(1'b0, 5'd5, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3, 1);
    issue(1'b1, 5'd7, 32'h1234_5678, 10, 1'b0, 1'b0, 32'hDEAD_BEEF, 12, 0);
    issue(1'b0, 5'd7, 32'h0, 3, 1'b1, 1'b0, 32'h1234_5678, 5, 1);
    issue(1'b0, 5'd3, 32'h0, 255, 1'b0, 1'b1, 32'h1234_5678, 17, 0);
    issue(1'b1, 5'd0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h1234_5678, 3, 0);

    // Request withdrawn while stalled: back to idle, no ack
    @(negedge clk);
    req = 1'b1; wr = 1'b0; idx = 5'd5; pipe_idle = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_stall_high", 64'(stall), 64'd1);
    req = 1'b0;
    @(negedge clk);
    check("abort_stall_fall", 64'(stall), 64'd0);
    pipe_idle = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted during ACCESS of a write
    req = 1'b1; wr = 1'b1; idx = 5'd9; wdata = 32'hAAAA_5555;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mid_wr_en_pre", 64'(wr_en), 64'd1);
    rst_b = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({ack, err, stall, rd_sel, wr_en}), 64'd0);
    check("rst_mid_rdata", 64'(rdata), 64'd0);
    req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_release_idle", 64'(stall), 64'd0);

    issue(1'b0, 5'd9, 32'h0, 0, 1'b0, 1'b0, 32'h0, 3, 1);
    issue(1'b0, 5'd5, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3, 1);
    issue(1'b0, 5'd0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 3, 1);

    repeat (3) @(negedge clk);
    check("ack_queue_empty", 64'(ack_q.size()), 64'd0);
    check("wr_queue_empty",  64'(wr_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cr_iu_oper_dbg_acc.md
# cr_iu_oper_dbg_acc

Debug GPR access sequencer for the IU operand stage. It accepts single-register read and write requests from the HAD debug unit. For each request it:
- stalls instruction issue;
- waits for the EX/WB pipeline to drain;
- takes over GPR read port 0 or injects a write into the GPR write mux;
- returns data and status to HAD with a one-cycle acknowledge.

It sits between HAD, the IU control block and the operand/GPR datapath.

## Interface
Parameters:
- TIMEOUT, 64: cycles to wait in STALL for pipeline idle before aborting with error; legal range 2..255.

Ports:
- forever_cpuclk  in  1  core clock.
- cpurst_b  in  1  asynchronous, active-low reset.
- had_oper_req  in  1  access request; level, held by HAD until ack.
- had_oper_wr  in  1  1 = write, 0 = read; stable while req high.
- had_oper_idx  in  5  target GPR index.
- had_oper_wdata  in  32  write data.
- oper_had_ack  out  1  one-cycle completion pulse.
- oper_had_err  out  1  timeout status; valid with ack, held until next ack.
- oper_had_rdata  out  32  read data; valid with ack, held until next ack.
- ctrl_oper_pipe_idle  in  1  EX and WB hold no valid instruction.
- wb_oper_write_en  in  1  pipeline GPR write this cycle.
- oper_ctrl_pipe_stall  out  1  blocks instruction issue into EX.
- oper_gpr_rd_sel  out  1  selects oper_gpr_rd_idx onto read port 0.
- oper_gpr_rd_idx  out  5  debug read index.
- oper_rs1_gpr_data  in  32  read port 0 data (combinational from GPR).
- oper_gpr_wr_en  out  1  debug write strobe into GPR write mux.
- oper_gpr_wr_idx  out  5  debug write index.
- oper_gpr_wr_data  out  32  debug write data.

## Operation
- FSM states: IDLE, STALL, ACCESS, ACK, DROP; encoding 3 bits, one-hot optional.
- IDLE:
  - req=1 -> STALL.
  - Latch idx, wr and wdata into internal registers.
  - Clear the timeout counter.
- STALL:
  - stall=1.
  - If req=0 -> IDLE (abort; no ack).
  - Else if pipe_idle=1 and wb_oper_write_en=0 -> ACCESS.
  - Else if counter==TIMEOUT-1 -> ACK with err=1; no GPR access, rdata unchanged.
  - Else counter+1.
  - Idle condition wins over timeout in the same cycle.
- ACCESS, lasts one cycle:
  - Read: rd_sel=1, rd_idx=latched idx; rdata <= oper_rs1_gpr_data at the clock edge; forced to 0 when idx==0.
  - Write: wr_en=1 with latched idx/wdata; wr_en is suppressed when idx==0.
  - err <= 0.
  - -> ACK unconditionally. A request dropped during ACCESS still completes.
- ACK: ack=1 for one cycle -> DROP.
- DROP: stall=1; wait for req=0 -> IDLE. A new request can only be taken after req has been low for at least one IDLE cycle.
- Output decoding:
  - stall=1 in STALL, ACCESS, ACK and DROP.
  - rd_sel, wr_en and ack are decoded from registered state (Moore); no combinational path from had_* to outputs.
- Counter: 8 bits, saturating; not compared outside STALL.

## Timing
- Reset values: state=IDLE; ack, err, stall, rd_sel, wr_en = 0; rdata, rd_idx, wr_idx, wr_data = 0; counter = 0.
- Reset is asynchronous: assertion mid-operation returns to IDLE immediately and drops stall/wr_en in the same cycle; no partial write is retried.
- Minimum latency with the pipeline already idle:
  - req sampled at edge 0.
  - STALL in cycle 1.
  - ACCESS in cycle 2; wr_en high, read sampled.
  - ack in cycle 3.
- Timeout latency: ack at cycle TIMEOUT+1 after the req edge.
- Write becomes visible to EX reads the cycle after ACCESS. Stall stays high through DROP, so no instruction observes the intermediate state.
- wb_oper_write_en=1 with pipe_idle=1 holds STALL, so the write port never sees a same-cycle collision.

## Test plan
- Read r5 (GPR holds 0xDEADBEEF), pipe idle: ack in cycle 3, rdata=0xDEADBEEF, err=0; stall high cycles 1-4 until req drops.
- Write r7=0x12345678, pipe busy for 10 cycles: wr_en is a single pulse with idx=7, data=0x12345678 exactly one cycle after idle; ack the next cycle; a following read returns 0x12345678.
- Write r0=0xFFFFFFFF then read r0: no wr_en pulse, ack normal, read returns 0.
- TIMEOUT=16, pipe_idle stuck 0: ack with err=1 at cycle 17, no rd_sel/wr_en pulse, rdata unchanged from the previous access.
- Abort and reset: req dropped in STALL -> IDLE, no ack, stall falls next cycle; cpurst_b asserted during ACCESS of a write -> all outputs 0 immediately, state IDLE after release.
